// File: rtl/s15611_pkg.sv
// Shared types and constants for the S15611 acquisition sequencer:
// FSM states, sensor configuration table and the expected chip ID.
package s15611_pkg;

  typedef enum logic [2:0] {
    RST_HOLD, CFG_SHIFT, CFG_GAP, IDLE, MST_PULSE, READOUT, FAULT
  } acq_state_t;

  localparam int CFG_WORDS = 4;
  localparam int WIDX_W    = $clog2(CFG_WORDS + 1);

  // Entry 0 goes out first; the last entry is the ID read command.
  localparam logic [CFG_WORDS-1:0][15:0] CFG_TABLE = {
    16'h8F00, 16'h0301, 16'h0220, 16'h0100
  };

  localparam logic [15:0] S15611_ID = 16'h5611;

  // Index may run one past the table while the ID is evaluated; return 0 there.
  function automatic logic [15:0] cfg_word(input logic [WIDX_W-1:0] idx);
    cfg_word = '0;
    for (int i = 0; i < CFG_WORDS; i++)
      if (idx == WIDX_W'(i)) cfg_word = CFG_TABLE[i];
  endfunction

endpackage

// File: rtl/s15611_spi_shifter.sv
// One 16-bit SPI mode-0 transfer: MSB first, mosi changes while sclk is low,
// miso captured on every sclk rise. done is a strobe in the final cycle.
module s15611_spi_shifter #(
  parameter int SCLK_HALF_NCLK = 4
) (
  input  logic        master_clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] tx_word,
  input  logic        miso,
  output logic        done,
  output logic [15:0] rx_word,
  output logic        sclk,
  output logic        mosi
);

  localparam int HW = $clog2(SCLK_HALF_NCLK + 1);

  logic          active;
  logic [HW-1:0] half_cnt;
  logic [4:0]    edge_cnt;
  logic [15:0]   tx_sr;
  logic          half_last;

  assign half_last = (half_cnt == HW'(SCLK_HALF_NCLK - 1));
  // Combinational so the caller can raise cs on the same edge sclk returns low.
  assign done      = active && half_last && (edge_cnt == 5'd31);
  assign mosi      = tx_sr[15];

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      active   <= 1'b0;
      half_cnt <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_word  <= '0;
      sclk     <= 1'b0;
    end else if (!active) begin
      if (start) begin
        active   <= 1'b1;
        tx_sr    <= tx_word;
        half_cnt <= '0;
        edge_cnt <= '0;
        sclk     <= 1'b0;
      end
    end else if (!half_last) begin
      half_cnt <= half_cnt + 1'b1;
    end else begin
      half_cnt <= '0;
      edge_cnt <= edge_cnt + 1'b1;
      sclk     <= ~sclk;
      if (!sclk)
        rx_word <= {rx_word[14:0], miso};
      else if (done) begin
        active <= 1'b0;
        tx_sr  <= '0;
      end else
        tx_sr <= {tx_sr[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/s15611_acq_sequencer.sv
// S15611 line-sensor sequencer: reset pulse, SPI configuration with ID check,
// then periodic mst-triggered frame readout with timeout and overrun reporting.
module s15611_acq_sequencer
  import s15611_pkg::*;
#(
  parameter int NUMBER_OF_PIXEL      = 128,
  parameter int SCLK_HALF_NCLK       = 4,
  parameter int RSTB_WIDTH_NCLK      = 100,
  parameter int CFG_GAP_NCLK         = 8,
  parameter int MST_WIDTH_NCLK       = 4,
  parameter int READOUT_TIMEOUT_NCLK = 4096
) (
  input  logic        master_clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic [31:0] frame_period,
  input  logic        pixel_valid,
  input  logic        s15611_miso,
  output logic        s15611_rstb,
  output logic        s15611_cs,
  output logic        s15611_sclk,
  output logic        s15611_mosi,
  output logic        s15611_mst,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic        frame_done,
  output logic        frame_timeout,
  output logic        overrun,
  output logic        busy
);

  localparam int M1      = (RSTB_WIDTH_NCLK > READOUT_TIMEOUT_NCLK) ? RSTB_WIDTH_NCLK : READOUT_TIMEOUT_NCLK;
  localparam int M2      = (CFG_GAP_NCLK > MST_WIDTH_NCLK) ? CFG_GAP_NCLK : MST_WIDTH_NCLK;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PIX_W   = $clog2(NUMBER_OF_PIXEL + 1);

  acq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       period_cnt;
  logic [31:0]       fp_eff;
  logic [PIX_W-1:0]  pix_cnt;
  logic [WIDX_W-1:0] word_idx;
  logic              gap_last, words_left, run_state;
  logic              spi_start, spi_done;
  logic [15:0]       spi_rx;

  assign gap_last   = (cnt == CNT_W'(CFG_GAP_NCLK - 1));
  assign words_left = (word_idx != WIDX_W'(CFG_WORDS));
  assign spi_start  = (state == CFG_GAP) && gap_last && words_left;
  assign run_state  = (state == IDLE) || (state == MST_PULSE) || (state == READOUT);
  // A period shorter than the mst pulse plus one cycle cannot be honoured.
  assign fp_eff     = (frame_period < 32'(MST_WIDTH_NCLK + 1)) ? 32'(MST_WIDTH_NCLK + 1) : frame_period;

  s15611_spi_shifter #(.SCLK_HALF_NCLK(SCLK_HALF_NCLK)) u_spi (
    .master_clock (master_clock),
    .resetn       (resetn),
    .start        (spi_start),
    .tx_word      (cfg_word(word_idx)),
    .miso         (s15611_miso),
    .done         (spi_done),
    .rx_word      (spi_rx),
    .sclk         (s15611_sclk),
    .mosi         (s15611_mosi)
  );

  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      state         <= RST_HOLD;
      cnt           <= '0;
      period_cnt    <= '0;
      pix_cnt       <= '0;
      word_idx      <= '0;
      s15611_rstb   <= 1'b0;
      s15611_cs     <= 1'b1;
      s15611_mst    <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_error     <= 1'b0;
      frame_done    <= 1'b0;
      frame_timeout <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      frame_timeout <= 1'b0;
      busy          <= 1'b1;
      if (run_state && period_cnt != 32'd0) period_cnt <= period_cnt - 32'd1;

      case (state)
        RST_HOLD:
          if (cnt == CNT_W'(RSTB_WIDTH_NCLK - 1)) begin
            s15611_rstb <= 1'b1;
            cnt         <= '0;
            word_idx    <= '0;
            state       <= CFG_GAP;
          end else cnt <= cnt + 1'b1;

        CFG_GAP:
          if (gap_last) begin
            cnt <= '0;
            if (words_left) begin
              s15611_cs <= 1'b0;
              state     <= CFG_SHIFT;
            end else if (spi_rx == S15611_ID) begin
              cfg_done <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              cfg_error <= 1'b1;
              busy      <= 1'b0;
              state     <= FAULT;
            end
          end else cnt <= cnt + 1'b1;

        CFG_SHIFT:
          if (spi_done) begin
            s15611_cs <= 1'b1;
            word_idx  <= word_idx + 1'b1;
            cnt       <= '0;
            state     <= CFG_GAP;
          end

        IDLE: begin
          busy <= 1'b0;
          if (enable && period_cnt == 32'd0) begin
            s15611_mst <= 1'b1;
            period_cnt <= fp_eff - 32'd1;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= MST_PULSE;
          end
        end

        MST_PULSE:
          if (cnt == CNT_W'(MST_WIDTH_NCLK - 1)) begin
            s15611_mst <= 1'b0;
            cnt        <= '0;
            pix_cnt    <= '0;
            state      <= READOUT;
          end else cnt <= cnt + 1'b1;

        READOUT: begin
          if (period_cnt == 32'd0) overrun <= 1'b1;
          // A strobe wins over a coinciding timeout.
          if (pixel_valid) begin
            cnt <= '0;
            if (pix_cnt == PIX_W'(NUMBER_OF_PIXEL - 1)) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else pix_cnt <= pix_cnt + 1'b1;
          end else if (cnt == CNT_W'(READOUT_TIMEOUT_NCLK - 1)) begin
            frame_timeout <= 1'b1;
            cnt           <= '0;
            busy          <= 1'b0;
            state         <= IDLE;
          end else cnt <= cnt + 1'b1;
        end

        FAULT: busy <= 1'b0;

        default: begin
          busy  <= 1'b0;
          state <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: doc/s15611_acq_sequencer.md
S15611_ACQ_SEQUENCER -- requirements
Module: s15611_acq_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  - NUMBER_OF_PIXEL, 128: pixels per frame.
  - SCLK_HALF_NCLK, 4: master_clock cycles per SCLK half period.
  - RSTB_WIDTH_NCLK, 100: rstb low time.
  - CFG_GAP_NCLK, 8: cs-high time between SPI words.
  - MST_WIDTH_NCLK, 4: mst pulse width.
  - READOUT_TIMEOUT_NCLK, 4096: maximum gap between pixels.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  - master_clock, in, 1: sole clock.
  - resetn, in, 1: asynchronous active-low reset.
  - enable, in, 1: level; run periodic acquisition.
  - frame_period, in, 32: master_clock cycles from mst rise to the next mst rise.
  - pixel_valid, in, 1: one-cycle strobe per pixel from the sensor driver.
  - s15611_miso, in, 1: SPI readback.
  - s15611_rstb, out, 1: sensor reset, low active.
  - s15611_cs, out, 1: SPI chip select, low active.
  - s15611_sclk, out, 1: SPI clock.
  - s15611_mosi, out, 1: SPI data out.
  - s15611_mst, out, 1: frame start pulse.
  - cfg_done, out, 1: level; configuration passed.
  - cfg_error, out, 1: sticky; ID mismatch.
  - frame_done, out, 1: one-cycle pulse.
  - frame_timeout, out, 1: one-cycle pulse.
  - overrun, out, 1: sticky.
  - busy, out, 1: high outside IDLE and FAULT.

Function
REQ-003 The FSM SHALL have the states RST_HOLD, CFG_SHIFT, CFG_GAP, IDLE, MST_PULSE, READOUT and FAULT.
REQ-004 RST_HOLD SHALL drive rstb=0 for RSTB_WIDTH_NCLK cycles, then rstb=1 and go to CFG_GAP with word index 0.
REQ-005 CFG_GAP SHALL hold cs=1 for CFG_GAP_NCLK cycles, then go to CFG_SHIFT if words remain, else evaluate the ID.
REQ-006 CFG_SHIFT SHALL use SPI mode 0: cs=0; 16 bits MSB first; mosi updated while sclk=0; sclk toggling every SCLK_HALF_NCLK cycles, idling at 0; after the 16th bit go to CFG_GAP with index+1.
REQ-007 The final table word SHALL be a read: miso is sampled on each sclk rising edge into a 16-bit shift register.
REQ-008 After the last word, a readback equal to S15611_ID SHALL set cfg_done=1 and go to IDLE; otherwise it SHALL set cfg_error=1 and go to FAULT.
REQ-009 FAULT SHALL be terminal until reset, with all outputs at their idle values.
REQ-010 In IDLE with enable=1, the block SHALL go to MST_PULSE on the next cycle and load the period counter with frame_period-1.
REQ-011 MST_PULSE SHALL drive mst=1 for MST_WIDTH_NCLK cycles, then go to READOUT with pixel count 0.
REQ-012 READOUT SHALL count pixel_valid; on the NUMBER_OF_PIXEL-th strobe it SHALL pulse frame_done in the following cycle and return to IDLE.
REQ-013 The gap counter SHALL clear on every pixel_valid; when it reaches READOUT_TIMEOUT_NCLK it SHALL pulse frame_timeout and return to IDLE.
REQ-014 The period counter SHALL run in all run states; the next mst SHALL occur only when the counter is 0, the state is IDLE and enable=1.
REQ-015 If the counter reaches 0 while in READOUT, overrun SHALL be set and the mst SHALL issue immediately on return to IDLE.
REQ-016 A frame_period value below MST_WIDTH_NCLK+1 SHALL be treated as MST_WIDTH_NCLK+1.
REQ-017 The period counter SHALL saturate at 0 and never wrap.
REQ-018 Deasserting enable SHALL let an in-progress frame complete, with no further mst.
REQ-019 pixel_valid outside READOUT SHALL be ignored.
REQ-020 A simultaneous last pixel and timeout SHALL report frame_done only.

Reset
REQ-021 resetn=0 SHALL asynchronously force state RST_HOLD and all counters to 0.
REQ-022 During reset the outputs SHALL be rstb=0, cs=1, sclk=0, mosi=0, mst=0, and cfg_done, cfg_error, frame_done, frame_timeout, overrun and busy all 0.
REQ-023 Reset asserted mid-SPI or mid-frame SHALL abort the operation; the full configuration sequence SHALL rerun after release.

Structure
REQ-024 Package s15611_pkg SHALL hold:
  - the state enum;
  - CFG_WORDS, the count;
  - the CFG_TABLE 16-bit constant array, whose last entry is the read command;
  - S15611_ID.
REQ-025 Sub-module s15611_spi_shifter SHALL implement one 16-bit mode-0 transfer with start, done, tx_word and rx_word ports; the FSM SHALL sequence it.

Verification
REQ-026 Reset release with the model returning S15611_ID -> rstb low 100 cycles; CFG_WORDS transfers each 128 cycles with sclk period 8; cfg_done=1; cfg_error=0.
REQ-027 Model returns 0x0000 on readback -> cfg_error=1; state FAULT; no mst ever, even with enable=1.
REQ-028 frame_period=2000, enable=1, 128 pixel strobes per frame -> mst rises every 2000 cycles; frame_done once per frame; overrun=0.
REQ-029 frame_period=500 with readout lasting 800 cycles -> overrun=1; next mst in the cycle after return to IDLE.
REQ-030 Only 100 pixel strobes, then silence -> frame_timeout pulse 4096 cycles after the last strobe; no frame_done.
REQ-031 resetn asserted during the 3rd SPI word -> cs=1 and rstb=0 immediately; a complete configuration follows release.
